// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    BR_FLUSH   = 2'b10,
    MEM_WAIT   = 2'b11
  } hz_state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int ZERO_REG = 0;

  // Wide enough for a branch squash of up to four cycles.
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_fwd_unit.sv
// rtl/pipeline_fwd_unit.sv - combinational operand-forwarding select for one EX source
module pipeline_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] src_reg,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_write,
  output logic [1:0]            fwd_sel
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  logic exmem_hit;
  logic memwb_hit;

  // Register 0 never forwards; the younger EX/MEM result beats MEM/WB.
  always_comb begin
    exmem_hit = exmem_write && (exmem_rd != ZERO_IDX) && (exmem_rd == src_reg);
    memwb_hit = memwb_write && (memwb_rd != ZERO_IDX) && (memwb_rd == src_reg);
    if (exmem_hit) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      fwd_sel = FWD_MEMWB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding control for a five-stage pipeline
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W          = 3,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_use,
  input  logic                  id_rt_use,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_write,
  input  logic                  idex_load,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_write,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  perf_clear,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_hold,
  output logic                  exmem_hold,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            state_dbg,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [REG_ADDR_W-1:0]  ZERO_IDX    = REG_ADDR_W'(ZERO_REG);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam bit                     MULTI_FLUSH = (BRANCH_FLUSH_CYCLES > 1);

  hz_state_t              state;
  hz_state_t              state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;

  logic mem_stall;
  logic load_use;
  logic hold_all;
  logic lu_stall;
  logic br_squash;
  logic br_tail;

  // Raw hazard conditions from the stage-register control fields.
  always_comb begin
    mem_stall = mem_req && !mem_ready;
    load_use  = idex_load && idex_write && (idex_rd != ZERO_IDX) &&
                ((id_rs_use && (id_rs == idex_rd)) || (id_rt_use && (id_rt == idex_rd)));
  end

  // Next-state and per-cycle hold/flush intent; a memory wait always outranks
  // branch and load-use handling because every stage is frozen anyway.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    hold_all      = 1'b0;
    lu_stall      = 1'b0;
    br_squash     = 1'b0;
    br_tail       = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          hold_all  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (ex_branch_taken) begin
          br_squash = 1'b1;
          if (MULTI_FLUSH) begin
            flush_cnt_nxt = FLUSH_LOAD;
            state_nxt     = BR_FLUSH;
          end
        end else if (load_use) begin
          lu_stall  = 1'b1;
          state_nxt = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        // The bubble is already in ID/EX, so the hazard cannot recur here.
        if (mem_stall) begin
          hold_all  = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
      BR_FLUSH: begin
        // EX holds a bubble, so ex_branch_taken is meaningless in this state.
        if (mem_stall) begin
          hold_all = 1'b1;
        end else begin
          br_tail       = 1'b1;
          flush_cnt_nxt = flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) begin
            state_nxt = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          hold_all = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Mealy hold/flush outputs, forced quiet while reset is asserted.
  always_comb begin
    pc_hold    = reset && (hold_all || lu_stall);
    ifid_hold  = reset && (hold_all || lu_stall);
    idex_hold  = reset && hold_all;
    exmem_hold = reset && hold_all;
    ifid_flush = reset && (br_squash || br_tail);
    idex_flush = reset && (br_squash || lu_stall);
    state_dbg  = state;
  end

  // FSM state and branch-squash countdown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Saturating count of PC-hold cycles; a clear request wins over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (perf_clear) begin
      stall_count <= '0;
    end else if (pc_hold && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  pipeline_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_reg     (ex_rs),
    .exmem_rd    (exmem_rd),
    .exmem_write (exmem_write),
    .memwb_rd    (memwb_rd),
    .memwb_write (memwb_write),
    .fwd_sel     (fwd_a)
  );

  pipeline_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_reg     (ex_rt),
    .exmem_rd    (exmem_rd),
    .exmem_write (exmem_write),
    .memwb_rd    (memwb_rd),
    .memwb_write (memwb_write),
    .fwd_sel     (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int RW      = 3;
  localparam int BFC     = 3;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, idex_rd, exmem_rd, memwb_rd;
  logic          id_rs_use, id_rt_use, idex_write, idex_load, exmem_write, memwb_write;
  logic          ex_branch_taken, mem_req, mem_ready, perf_clear;
  logic          pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush;
  logic [1:0]    fwd_a, fwd_b, state_dbg;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int passed = 0;

  // Reference model: pending work expressed as plain counters and flags.
  bit m_wait;
  int m_flush_left;
  bit m_after_load;
  int m_cnt;

  int e_pc, e_ifid_h, e_idex_h, e_exmem_h, e_ifid_f, e_idex_f, e_fa, e_fb, e_state;
  int o_pc, o_ifid_h, o_idex_h, o_exmem_h, o_ifid_f, o_idex_f, o_fa, o_fb, o_state;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .BRANCH_FLUSH_CYCLES(BFC), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .idex_rd(idex_rd), .idex_write(idex_write),
    .idex_load(idex_load), .exmem_rd(exmem_rd), .exmem_write(exmem_write),
    .memwb_rd(memwb_rd), .memwb_write(memwb_write), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .perf_clear(perf_clear),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state_dbg(state_dbg), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    id_rs_use = 0; id_rt_use = 0; idex_write = 0; idex_load = 0; exmem_write = 0; memwb_write = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0; perf_clear = 0;
  endtask

  function automatic int fwd_ref(int src, bit exw, int exrd, bit mww, int mwrd);
    if (exw && exrd != 0 && exrd == src) return 2;
    if (mww && mwrd != 0 && mwrd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_flush_left = 0; m_after_load = 0; m_cnt = 0;
  endtask

  task automatic model_outputs();
    bit stall, lu;
    stall = mem_req && !mem_ready;
    lu = idex_load && idex_write && idex_rd != 0 &&
         ((id_rs_use && id_rs == idex_rd) || (id_rt_use && id_rt == idex_rd));
    e_pc = 0; e_ifid_h = 0; e_idex_h = 0; e_exmem_h = 0; e_ifid_f = 0; e_idex_f = 0;
    if (m_wait) begin
      if (!mem_ready) begin e_pc = 1; e_ifid_h = 1; e_idex_h = 1; e_exmem_h = 1; end
    end else if (m_flush_left > 0) begin
      if (stall) begin e_pc = 1; e_ifid_h = 1; e_idex_h = 1; e_exmem_h = 1; end
      else e_ifid_f = 1;
    end else if (m_after_load) begin
      if (stall) begin e_pc = 1; e_ifid_h = 1; e_idex_h = 1; e_exmem_h = 1; end
    end else if (stall) begin
      e_pc = 1; e_ifid_h = 1; e_idex_h = 1; e_exmem_h = 1;
    end else if (ex_branch_taken) begin
      e_ifid_f = 1; e_idex_f = 1;
    end else if (lu) begin
      e_pc = 1; e_ifid_h = 1; e_idex_f = 1;
    end
    e_fa = fwd_ref(int'(ex_rs), exmem_write, int'(exmem_rd), memwb_write, int'(memwb_rd));
    e_fb = fwd_ref(int'(ex_rt), exmem_write, int'(exmem_rd), memwb_write, int'(memwb_rd));
    e_state = m_wait ? 3 : (m_flush_left > 0) ? 2 : m_after_load ? 1 : 0;
  endtask

  task automatic model_advance();
    bit stall;
    stall = mem_req && !mem_ready;
    if (perf_clear) m_cnt = 0;
    else if (e_pc != 0 && m_cnt < CNT_MAX) m_cnt++;
    if (m_wait) m_wait = !mem_ready;
    else if (m_flush_left > 0) begin
      if (!stall) m_flush_left--;
    end else if (m_after_load) begin
      m_after_load = 0;
      if (stall) m_wait = 1;
    end else if (stall) m_wait = 1;
    else if (ex_branch_taken) m_flush_left = BFC - 1;
    else if (e_idex_f != 0) m_after_load = 1;
  endtask

  // One clock: inputs already driven after a falling edge; sample mid-low-phase.
  task automatic cycle(input bit chk);
    #2;
    model_outputs();
    o_pc = int'(pc_hold); o_ifid_h = int'(ifid_hold); o_idex_h = int'(idex_hold);
    o_exmem_h = int'(exmem_hold); o_ifid_f = int'(ifid_flush); o_idex_f = int'(idex_flush);
    o_fa = int'(fwd_a); o_fb = int'(fwd_b); o_state = int'(state_dbg);
    if (chk) begin
      check("pc_hold", 32'(pc_hold), 32'(e_pc));
      check("ifid_hold", 32'(ifid_hold), 32'(e_ifid_h));
      check("idex_hold", 32'(idex_hold), 32'(e_idex_h));
      check("exmem_hold", 32'(exmem_hold), 32'(e_exmem_h));
      check("ifid_flush", 32'(ifid_flush), 32'(e_ifid_f));
      check("idex_flush", 32'(idex_flush), 32'(e_idex_f));
      check("fwd_a", 32'(fwd_a), 32'(e_fa));
      check("fwd_b", 32'(fwd_b), 32'(e_fb));
      check("state_dbg", 32'(state_dbg), 32'(e_state));
      check("stall_count", 32'(stall_count), 32'(m_cnt));
    end
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    #12;
    check("rst_pc_hold", 32'(pc_hold), 32'd0);
    check("rst_idex_flush", 32'(idex_flush), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Load-use on rs
    idex_load = 1; idex_write = 1; idex_rd = 3'd3; id_rs = 3'd3; id_rs_use = 1;
    cycle(1);
    check("lu_pc_hold", 32'(o_pc), 32'd1);
    check("lu_ifid_hold", 32'(o_ifid_h), 32'd1);
    check("lu_idex_flush", 32'(o_idex_f), 32'd1);
    cycle(1);
    check("lu_stall_state", 32'(o_state), 32'd1);
    check("lu_stall_quiet", 32'(o_pc + o_ifid_h + o_idex_f + o_ifid_f), 32'd0);
    idle();
    check("lu_back_run", 32'(state_dbg), 32'd0);
    check("lu_count", 32'(stall_count), 32'd1);

    // Register 0 never hazards or forwards
    idex_load = 1; idex_write = 1; idex_rd = 3'd0; id_rs = 3'd0; id_rs_use = 1;
    exmem_rd = 3'd0; ex_rs = 3'd0; exmem_write = 1;
    cycle(1);
    check("r0_no_stall", 32'(o_pc), 32'd0);
    check("r0_no_fwd", 32'(o_fa), 32'd0);
    idle();

    // EX/MEM beats MEM/WB, then MEM/WB alone
    exmem_rd = 3'd5; memwb_rd = 3'd5; exmem_write = 1; memwb_write = 1; ex_rs = 3'd5; ex_rt = 3'd5;
    cycle(1);
    check("fwd_a_exmem", 32'(o_fa), 32'd2);
    check("fwd_b_exmem", 32'(o_fb), 32'd2);
    exmem_write = 0;
    cycle(1);
    check("fwd_a_memwb", 32'(o_fa), 32'd1);
    check("fwd_b_memwb", 32'(o_fb), 32'd1);
    idle();

    // Taken branch with a three-cycle squash
    ex_branch_taken = 1;
    cycle(1);
    check("br0_state", 32'(o_state), 32'd0);
    check("br0_ifid", 32'(o_ifid_f), 32'd1);
    check("br0_idex", 32'(o_idex_f), 32'd1);
    ex_branch_taken = 0;
    cycle(1);
    check("br1_state", 32'(o_state), 32'd2);
    check("br1_ifid", 32'(o_ifid_f), 32'd1);
    check("br1_idex", 32'(o_idex_f), 32'd0);
    cycle(1);
    check("br2_state", 32'(o_state), 32'd2);
    check("br2_ifid", 32'(o_ifid_f), 32'd1);
    check("br3_state", 32'(state_dbg), 32'd0);
    cycle(1);
    check("br3_ifid", 32'(o_ifid_f), 32'd0);

    // Memory wait outranks load-use and branch
    perf_clear = 1;
    cycle(1);
    perf_clear = 0;
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    idex_load = 1; idex_write = 1; idex_rd = 3'd2; id_rt = 3'd2; id_rt_use = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      check("mw_holds", 32'(o_pc + o_ifid_h + o_idex_h + o_exmem_h), 32'd4);
      check("mw_no_flush", 32'(o_ifid_f + o_idex_f), 32'd0);
    end
    mem_ready = 1;
    cycle(1);
    check("mw_ready_holds", 32'(o_pc + o_ifid_h + o_idex_h + o_exmem_h), 32'd0);
    check("mw_ready_flush", 32'(o_ifid_f + o_idex_f), 32'd0);
    idle();
    check("mw_count", 32'(stall_count), 32'd4);

    // Asynchronous reset in the middle of a memory wait
    mem_req = 1; mem_ready = 0;
    cycle(1);
    cycle(1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_holds", 32'(pc_hold | ifid_hold | idex_hold | exmem_hold), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    model_reset();
    idle();
    @(negedge clock);
    reset = 1'b1;
    check("arst_rel_state", 32'(state_dbg), 32'd0);
    check("arst_rel_count", 32'(stall_count), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
      ex_rs = RW'($urandom_range(0, 3)); ex_rt = RW'($urandom_range(0, 3));
      idex_rd = RW'($urandom_range(0, 3)); exmem_rd = RW'($urandom_range(0, 3));
      memwb_rd = RW'($urandom_range(0, 3));
      id_rs_use = 1'($urandom_range(0, 1)); id_rt_use = 1'($urandom_range(0, 1));
      idex_write = 1'($urandom_range(0, 1)); idex_load = 1'($urandom_range(0, 1));
      exmem_write = 1'($urandom_range(0, 1)); memwb_write = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom_range(0, 1));
      perf_clear = ($urandom_range(0, 19) == 0);
      cycle(1);
    end
    idle();
    cycle(1);

    // Counter saturation and clear
    perf_clear = 1;
    cycle(1);
    perf_clear = 0;
    mem_req = 1; mem_ready = 0;
    for (int n = 0; n < CNT_MAX + 5; n++) cycle(0);
    check("sat_count", 32'(stall_count), 32'hFFFF);
    check("sat_model", 32'(stall_count), 32'(m_cnt));
    perf_clear = 1;
    cycle(0);
    check("clear_wins", 32'(stall_count), 32'd0);
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
